// File: rtl/ppi_pkg.sv
// Shared encodings for the strobed parallel peripheral interface: config fields, status layout, register map.
// Latency: none (constants only). Backpressure: not applicable.
// Build option PPI_INTR_EN enables the interrupt path in the port channels.
package ppi_pkg;

    typedef enum logic {
        MODE_SIMPLE  = 1'b0,
        MODE_STROBED = 1'b1
    } ppi_mode_e;

    typedef enum logic {
        DIR_IN  = 1'b0,
        DIR_OUT = 1'b1
    } ppi_dir_e;

    // Control word field positions
    localparam int CTL_DIR      = 0;
    localparam int CTL_MODE     = 1;
    localparam int CTL_INTE     = 2;
    localparam int CTL_CFG_W    = 3;
    localparam int CTL_PSEL_LSB = 4;

    // Status word: one 3-bit group per port
    localparam int STS_BF   = 0;
    localparam int STS_INTR = 1;
    localparam int STS_OVR  = 2;
    localparam int STS_BITS = 3;

    // Register addresses above the port data registers
    localparam int ADDR_OFS_STATUS  = 0;
    localparam int ADDR_OFS_CONTROL = 1;

endpackage

// File: rtl/ppi_port_channel.sv
// One PPI port: config, in/out buffers, stb/ack edge detect, ibf/obf/overrun/interrupt flags.
// Latency: flags and buffers update on the edge after the access or strobe. Backpressure: none; overrun flags lost strobes.
// PPI_INTR_EN builds inte/intr_flag; otherwise intr is tied low.
module ppi_port_channel
    import ppi_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_wr,
    input  logic [CTL_CFG_W-1:0] cfg_dat,
    input  logic                 data_wr,
    input  logic                 data_rd,
    input  logic                 ovr_clr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [DATA_W-1:0]    pin_dat,
    input  logic                 stb,
    input  logic                 ack,
    output logic [DATA_W-1:0]    rd_dat,
    output logic [DATA_W-1:0]    port_out,
    output logic                 port_oe,
    output logic                 ibf,
    output logic                 obf,
    output logic                 intr,
    output logic                 overrun
);

    ppi_mode_e          mode;
    ppi_dir_e           dir;
    logic [DATA_W-1:0]  in_reg;
    logic [DATA_W-1:0]  out_reg;
    logic               stb_q;
    logic               ack_q;

    logic strobed_in;
    logic strobed_out;
    logic stb_rise;
    logic ack_rise;
    logic ibf_set;
    logic ovr_set;

    assign strobed_in  = (mode == MODE_STROBED) && (dir == DIR_IN);
    assign strobed_out = (mode == MODE_STROBED) && (dir == DIR_OUT);
    assign stb_rise    = stb & ~stb_q;
    assign ack_rise    = ack & ~ack_q;

    // A read on the same edge frees the buffer, so the new strobe is accepted, not an overrun
    assign ibf_set = strobed_in & stb_rise & (~ibf | data_rd);
    assign ovr_set = strobed_in & stb_rise & ibf & ~data_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            mode    <= MODE_SIMPLE;
            dir     <= DIR_IN;
            in_reg  <= '0;
            out_reg <= '0;
            ibf     <= 1'b0;
            obf     <= 1'b0;
            overrun <= 1'b0;
            stb_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            stb_q <= stb;
            ack_q <= ack;
            if (cfg_wr) begin
                mode    <= ppi_mode_e'(cfg_dat[CTL_MODE]);
                dir     <= ppi_dir_e'(cfg_dat[CTL_DIR]);
                in_reg  <= '0;
                out_reg <= '0;
                ibf     <= 1'b0;
                obf     <= 1'b0;
                overrun <= 1'b0;
            end else begin
                if (dir == DIR_IN && (mode == MODE_SIMPLE || ibf_set)) begin
                    in_reg <= pin_dat;
                end

                if (ibf_set) begin
                    ibf <= 1'b1;
                end else if (data_rd) begin
                    ibf <= 1'b0;
                end

                if (ovr_set) begin
                    overrun <= 1'b1;
                end else if (ovr_clr) begin
                    overrun <= 1'b0;
                end

                if (data_wr && dir == DIR_OUT) begin
                    out_reg <= wdata;
                    if (strobed_out) begin
                        obf <= 1'b1;
                    end
                end else if (strobed_out && ack_rise) begin
                    obf <= 1'b0;
                end
            end
        end
    end

`ifdef PPI_INTR_EN
    logic inte;
    logic intr_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            inte      <= 1'b0;
            intr_flag <= 1'b0;
        end else if (cfg_wr) begin
            inte      <= cfg_dat[CTL_INTE];
            intr_flag <= 1'b0;
        end else if (strobed_out && data_wr) begin
            intr_flag <= 1'b0;
        end else if (strobed_out && ack_rise) begin
            intr_flag <= 1'b1;
        end
    end

    // ibf only ever sets in strobed input, intr_flag only in strobed output
    assign intr = inte & (ibf | intr_flag);
`else
    logic unused_inte;
    assign unused_inte = cfg_dat[CTL_INTE];
    assign intr        = 1'b0;
`endif

    assign rd_dat   = (dir == DIR_OUT) ? out_reg : in_reg;
    assign port_oe  = (dir == DIR_OUT);
    assign port_out = (dir == DIR_OUT) ? out_reg : '0;

endmodule

// File: rtl/ppi_strobed_param.sv
// Parametrised strobed PPI: register bus decode, NUM_PORTS port channels, status mux, registered rdata.
// Latency: reads 1 cycle, writes visible after the access edge. Backpressure: none, one access per cycle.
// PPI_INTR_EN enables per-port interrupts; undefined ties intr and status intr bits to 0.
module ppi_strobed_param
    import ppi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cs,
    input  logic                        wr,
    input  logic                        rd,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [DATA_W-1:0]           wdata,
    output logic [DATA_W-1:0]           rdata,
    input  logic [NUM_PORTS*DATA_W-1:0] port_in,
    output logic [NUM_PORTS*DATA_W-1:0] port_out,
    output logic [NUM_PORTS-1:0]        port_oe,
    input  logic [NUM_PORTS-1:0]        stb,
    input  logic [NUM_PORTS-1:0]        ack,
    output logic [NUM_PORTS-1:0]        ibf,
    output logic [NUM_PORTS-1:0]        obf,
    output logic [NUM_PORTS-1:0]        intr
);

    localparam int                PSEL_W       = DATA_W - CTL_PSEL_LSB;
    localparam logic [ADDR_W-1:0] ADDR_STATUS  = ADDR_W'(NUM_PORTS + ADDR_OFS_STATUS);
    localparam logic [ADDR_W-1:0] ADDR_CONTROL = ADDR_W'(NUM_PORTS + ADDR_OFS_CONTROL);

    logic              wr_acc;
    logic              rd_acc;
    logic              ctl_wr;
    logic              sts_rd;
    logic [PSEL_W-1:0] psel;
    logic [DATA_W-1:0] chan_rd_dat [NUM_PORTS];
    logic [NUM_PORTS-1:0] overrun;
    logic [DATA_W-1:0] sts_dat;
    logic [DATA_W-1:0] rd_mux;

    // Simultaneous wr and rd is not a legal access
    assign wr_acc = cs & wr & ~rd;
    assign rd_acc = cs & rd & ~wr;
    assign ctl_wr = wr_acc & (addr == ADDR_CONTROL);
    assign sts_rd = rd_acc & (addr == ADDR_STATUS);
    assign psel   = wdata[DATA_W-1:CTL_PSEL_LSB];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        localparam logic [ADDR_W-1:0] PORT_ADDR = ADDR_W'(i);

        ppi_port_channel #(
            .DATA_W (DATA_W)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .cfg_wr   (ctl_wr && (psel == PSEL_W'(i))),
            .cfg_dat  (wdata[CTL_CFG_W-1:0]),
            .data_wr  (wr_acc && (addr == PORT_ADDR)),
            .data_rd  (rd_acc && (addr == PORT_ADDR)),
            .ovr_clr  (sts_rd),
            .wdata    (wdata),
            .pin_dat  (port_in[i*DATA_W +: DATA_W]),
            .stb      (stb[i]),
            .ack      (ack[i]),
            .rd_dat   (chan_rd_dat[i]),
            .port_out (port_out[i*DATA_W +: DATA_W]),
            .port_oe  (port_oe[i]),
            .ibf      (ibf[i]),
            .obf      (obf[i]),
            .intr     (intr[i]),
            .overrun  (overrun[i])
        );
    end

    always_comb begin
        sts_dat = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sts_dat[STS_BITS*i + STS_BF]   = ibf[i] | obf[i];
            sts_dat[STS_BITS*i + STS_INTR] = intr[i];
            sts_dat[STS_BITS*i + STS_OVR]  = overrun[i];
        end
    end

    // Control and unmapped addresses fall through to 0
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr == ADDR_W'(i)) begin
                rd_mux = chan_rd_dat[i];
            end
        end
        if (addr == ADDR_STATUS) begin
            rd_mux = sts_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (rd_acc) begin
            rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_ppi_strobed_param.sv
// Directed bench for ppi_strobed_param (DATA_W=8, NUM_PORTS=2): reset, handshakes, overrun, same-edge cases.
module tb_ppi_strobed_param;

`ifdef PPI_INTR_EN
    localparam logic INTR_ON = 1'b1;
`else
    localparam logic INTR_ON = 1'b0;
`endif
    localparam logic [7:0] INTR_P1 = INTR_ON ? 8'h10 : 8'h00;
    localparam logic [7:0] INTR_P0 = INTR_ON ? 8'h02 : 8'h00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [1:0]  addr = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic [15:0] port_in = '0;
    logic [15:0] port_out;
    logic [1:0]  port_oe, stb = '0, ack = '0, ibf, obf, intr;

    int n_vec = 0;
    int n_miss = 0;

    ppi_strobed_param #(.DATA_W(8), .NUM_PORTS(2), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset), .cs(cs), .wr(wr), .rd(rd), .addr(addr),
        .wdata(wdata), .rdata(rdata), .port_in(port_in), .port_out(port_out),
        .port_oe(port_oe), .stb(stb), .ack(ack), .ibf(ibf), .obf(obf), .intr(intr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
        tick();
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        cs = 1'b1; rd = 1'b1; addr = a;
        tick();
        cs = 1'b0; rd = 1'b0;
        d = rdata;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        n_vec++; if ({port_oe, intr, ibf, obf} !== 8'h00) begin n_miss++;
            $display("FAIL rst_flags: oe/intr/ibf/obf got %b want 00000000", {port_oe, intr, ibf, obf}); end
        n_vec++; if ({port_out, rdata} !== 24'h0) begin n_miss++;
            $display("FAIL rst_data: port_out/rdata got %h want 000000", {port_out, rdata}); end
        port_in[7:0] = 8'hA5;
        tick();
        bus_read(2'd0, d);
        n_vec++; if (d !== 8'hA5) begin n_miss++;
            $display("FAIL mode0_read: got %h want a5", d); end
    endtask

    task automatic test_strobe_in();
        logic [7:0] d;
        bus_write(2'd3, 8'h16);   // port 1, strobed input, inte
        port_in[15:8] = 8'h3C;
        stb[1] = 1'b1;
        tick();
        stb[1] = 1'b0;
        n_vec++; if (ibf !== 2'b10 || intr !== {INTR_ON, 1'b0}) begin n_miss++;
            $display("FAIL stb_set: ibf %b intr %b want 10 %b0", ibf, intr, INTR_ON); end
        tick();
        bus_read(2'd1, d);
        n_vec++; if (d !== 8'h3C) begin n_miss++;
            $display("FAIL stb_read: got %h want 3c", d); end
        n_vec++; if (ibf !== 2'b00 || intr !== 2'b00) begin n_miss++;
            $display("FAIL stb_clr: ibf %b intr %b want 00 00", ibf, intr); end
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        port_in[15:8] = 8'h11; stb[1] = 1'b1; tick(); stb[1] = 1'b0; tick();
        port_in[15:8] = 8'h22; stb[1] = 1'b1; tick(); stb[1] = 1'b0; tick();
        bus_read(2'd2, d);
        n_vec++; if (d !== (8'h28 | INTR_P1)) begin n_miss++;
            $display("FAIL ovr_status1: got %h want %h", d, 8'h28 | INTR_P1); end
        bus_read(2'd2, d);
        n_vec++; if (d !== (8'h08 | INTR_P1)) begin n_miss++;
            $display("FAIL ovr_status2: got %h want %h", d, 8'h08 | INTR_P1); end
        bus_read(2'd1, d);
        n_vec++; if (d !== 8'h11) begin n_miss++;
            $display("FAIL ovr_keep_first: got %h want 11", d); end
    endtask

    task automatic test_strobe_out();
        logic [7:0] d;
        bus_write(2'd3, 8'h07);   // port 0, strobed output, inte
        n_vec++; if (port_oe !== 2'b01 || obf !== 2'b00) begin n_miss++;
            $display("FAIL out_cfg: oe %b obf %b want 01 00", port_oe, obf); end
        bus_write(2'd0, 8'h5A);
        n_vec++; if (port_out !== 16'h005A || obf !== 2'b01 || intr !== 2'b00) begin n_miss++;
            $display("FAIL out_write: port_out %h obf %b intr %b want 005a 01 00", port_out, obf, intr); end
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;
        n_vec++; if (obf !== 2'b00 || intr !== {1'b0, INTR_ON}) begin n_miss++;
            $display("FAIL out_ack: obf %b intr %b want 00 0%b", obf, intr, INTR_ON); end
        tick();
        bus_read(2'd2, d);
        n_vec++; if (d !== INTR_P0) begin n_miss++;
            $display("FAIL out_status: got %h want %h", d, INTR_P0); end
        bus_write(2'd0, 8'h66);
        n_vec++; if (port_out !== 16'h0066 || obf !== 2'b01 || intr !== 2'b00) begin n_miss++;
            $display("FAIL out_rewrite: port_out %h obf %b intr %b want 0066 01 00", port_out, obf, intr); end
        bus_read(2'd0, d);
        n_vec++; if (d !== 8'h66) begin n_miss++;
            $display("FAIL out_readback: got %h want 66", d); end
    endtask

    task automatic test_same_edge();
        logic [7:0] d;
        ack[0] = 1'b1; tick(); ack[0] = 1'b0; tick();
        cs = 1'b1; wr = 1'b1; addr = 2'd0; wdata = 8'h77; ack[0] = 1'b1;
        tick();
        cs = 1'b0; wr = 1'b0; ack[0] = 1'b0;
        n_vec++; if (obf !== 2'b01 || intr !== 2'b00 || port_out !== 16'h0077) begin n_miss++;
            $display("FAIL wr_ack_edge: obf %b intr %b port_out %h want 01 00 0077", obf, intr, port_out); end
        port_in[15:8] = 8'h44; stb[1] = 1'b1; tick(); stb[1] = 1'b0; tick();
        port_in[15:8] = 8'h55;
        cs = 1'b1; rd = 1'b1; addr = 2'd1; stb[1] = 1'b1;
        tick();
        cs = 1'b0; rd = 1'b0; stb[1] = 1'b0;
        n_vec++; if (rdata !== 8'h44 || ibf !== 2'b10) begin n_miss++;
            $display("FAIL rd_stb_edge: rdata %h ibf %b want 44 10", rdata, ibf); end
        tick();
        bus_read(2'd2, d);
        n_vec++; if (d !== (8'h09 | INTR_P1)) begin n_miss++;
            $display("FAIL rd_stb_status: got %h want %h", d, 8'h09 | INTR_P1); end
        bus_read(2'd1, d);
        n_vec++; if (d !== 8'h55) begin n_miss++;
            $display("FAIL rd_stb_data: got %h want 55", d); end
    endtask

    task automatic test_bad_access();
        logic [7:0] d;
        cs = 1'b1; wr = 1'b1; rd = 1'b1; addr = 2'd0; wdata = 8'h99;
        tick();
        addr = 2'd3; wdata = 8'h00;
        tick();
        cs = 1'b0; wr = 1'b0; rd = 1'b0;
        n_vec++; if (rdata !== 8'h55 || port_out !== 16'h0077 || port_oe !== 2'b01 || obf !== 2'b01) begin n_miss++;
            $display("FAIL wr_rd_both: rdata %h port_out %h oe %b obf %b want 55 0077 01 01", rdata, port_out, port_oe, obf); end
        bus_write(2'd3, 8'h21);   // port 2 does not exist
        bus_write(2'd1, 8'hFF);   // port 1 is an input
        n_vec++; if (port_oe !== 2'b01 || port_out !== 16'h0077) begin n_miss++;
            $display("FAIL ignored_wr: oe %b port_out %h want 01 0077", port_oe, port_out); end
        bus_read(2'd3, d);
        n_vec++; if (d !== 8'h00) begin n_miss++;
            $display("FAIL ctl_read: got %h want 00", d); end
    endtask

    task automatic test_reset_mid();
        bus_write(2'd0, 8'hC3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++; if ({port_out, rdata} !== 24'h0 || {port_oe, intr, ibf, obf} !== 8'h00) begin n_miss++;
            $display("FAIL reset_mid: port_out %h rdata %h oe/intr/ibf/obf %b want all 0", port_out, rdata, {port_oe, intr, ibf, obf}); end
    endtask

    initial begin
        test_reset();
        test_strobe_in();
        test_overrun();
        test_strobe_out();
        test_same_edge();
        test_bad_access();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
